// File: rtl/vit_ctrl_pkg.sv
// Shared types for the Viterbi sequencing controller: state encoding,
// stage-enable bundle and the per-state decode.
package vit_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_P1    = 4'd1,
    S_P2    = 4'd2,
    S_P3    = 4'd3,
    S_RUN   = 4'd4,
    S_FILL  = 4'd5,
    S_TRACE = 4'd6,
    S_FLUSH = 4'd7,
    S_DONE  = 4'd8,
    S_ERR   = 4'd9
  } state_t;

  typedef struct packed {
    logic ce;
    logic s;
    logic bm;
    logic acs;
    logic m;
    logic t;
  } stage_t;

  function automatic stage_t stage_of(input state_t st);
    stage_t r;
    r = '0;
    case (st)
      S_P1:    r = 6'b110000;
      S_P2:    r = 6'b111000;
      S_P3:    r = 6'b111100;
      S_RUN:   r = 6'b111110;
      S_FILL:  r = 6'b110010;
      S_TRACE: r = 6'b110011;
      S_FLUSH: r = 6'b000011;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic busy_of(input state_t st);
    return !(st == S_IDLE || st == S_DONE || st == S_ERR);
  endfunction

endpackage

// File: rtl/vit_ctrl_cnt.sv
// Saturating up-counter with clear and a terminal-count flag against a
// run-time limit; clear wins over increment, nothing moves while en=0.
module vit_ctrl_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] last,
  output logic         tc
);

  logic [W-1:0] cnt;

  assign tc = (cnt == last);

  // Holding at the limit keeps the count from wrapping inside a state.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      if (clr) begin
        cnt <= '0;
      end else if (inc && !tc) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vit_seq_ctrl.sv
// Viterbi decoder sequencing controller: Moore FSM that steps the pipeline
// through prime, sync search, memory fill, traceback and flush.
module vit_seq_ctrl
  import vit_ctrl_pkg::*;
#(
  parameter int TB_DEPTH = 8,
  parameter int FRAME_W  = 11,
  parameter int SYNC_TO  = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               i_start,
  input  logic               i_mode,
  input  logic [FRAME_W-1:0] i_frame_len,
  input  logic               i_sync,
  output logic               o_en_ce,
  output logic               o_en_s,
  output logic               o_en_bm,
  output logic               o_en_acs,
  output logic               o_en_m,
  output logic               o_en_t,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_sync_err,
  output state_t             o_state
);

  localparam int TO_W = 16;
  localparam int FL_W = $clog2(TB_DEPTH + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(SYNC_TO - 1);
  localparam logic [FL_W-1:0] FL_LAST = FL_W'(TB_DEPTH - 1);

  state_t             state_q;
  state_t             nxt;
  logic               mode_q;
  logic [FRAME_W-1:0] len_q;
  logic [FRAME_W-1:0] sym_last;
  stage_t             stg_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic               cnt_clr;
  logic               to_tc;
  logic               fl_tc;
  logic               sym_tc;
  logic               start_ok;

  // A zero length traces a single symbol.
  assign sym_last = (len_q == '0) ? '0 : len_q - 1'b1;
  assign start_ok = i_start && (state_q == S_IDLE || state_q == S_ERR);
  assign cnt_clr  = (nxt != state_q);

  always_comb begin
    nxt = state_q;
    case (state_q)
      S_IDLE:  if (i_start) nxt = S_P1;
      S_P1:    nxt = S_P2;
      S_P2:    nxt = S_P3;
      S_P3:    nxt = S_RUN;
      S_RUN:   if (i_sync) nxt = S_FILL;
               else if (to_tc) nxt = S_ERR;
      S_FILL:  if (fl_tc) nxt = S_TRACE;
      S_TRACE: if (mode_q && sym_tc) nxt = S_FLUSH;
      S_FLUSH: if (fl_tc) nxt = S_DONE;
      S_DONE:  nxt = S_IDLE;
      S_ERR:   if (i_start) nxt = S_P1;
      default: nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      len_q   <= '0;
      stg_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (en) begin
      state_q <= nxt;
      stg_q   <= stage_of(nxt);
      busy_q  <= busy_of(nxt);
      done_q  <= (nxt == S_DONE);
      err_q   <= (nxt == S_ERR);
      if (start_ok) begin
        mode_q <= i_mode;
        len_q  <= i_frame_len;
      end
    end
  end

  vit_ctrl_cnt #(.W(TO_W)) u_to_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (cnt_clr),
    .inc  (state_q == S_RUN),
    .last (TO_LAST),
    .tc   (to_tc)
  );

  vit_ctrl_cnt #(.W(FL_W)) u_fl_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (cnt_clr),
    .inc  (state_q == S_FILL || state_q == S_FLUSH),
    .last (FL_LAST),
    .tc   (fl_tc)
  );

  vit_ctrl_cnt #(.W(FRAME_W)) u_sym_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (cnt_clr),
    .inc  (state_q == S_TRACE),
    .last (sym_last),
    .tc   (sym_tc)
  );

  assign o_en_ce    = stg_q.ce;
  assign o_en_s     = stg_q.s;
  assign o_en_bm    = stg_q.bm;
  assign o_en_acs   = stg_q.acs;
  assign o_en_m     = stg_q.m;
  assign o_en_t     = stg_q.t;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_sync_err = err_q;
  assign o_state    = state_q;

endmodule

// File: tb/tb_vit_seq_ctrl.sv
// Bench for vit_seq_ctrl: every cycle pushes the expected state/output word
// for the stimulus it drives, then pops it against the DUT after the edge.
module tb_vit_seq_ctrl;
  import vit_ctrl_pkg::*;

  localparam int W = 13;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        i_start = 1'b0;
  logic        i_mode = 1'b0;
  logic [10:0] i_frame_len = '0;
  logic        i_sync = 1'b0;
  logic        o_en_ce, o_en_s, o_en_bm, o_en_acs, o_en_m, o_en_t;
  logic        o_busy, o_done, o_sync_err;
  state_t      o_state;

  logic [W-1:0] exp_q[$];
  int           n_vec = 0;
  int           n_err = 0;
  string        tag = "reset";
  state_t       cur_st = S_IDLE;
  logic         alt_en = 1'b0;
  logic         mode_v = 1'b0;
  logic [10:0]  len_v = '0;

  vit_seq_ctrl #(.TB_DEPTH(8), .FRAME_W(11), .SYNC_TO(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .i_start     (i_start),
    .i_mode      (i_mode),
    .i_frame_len (i_frame_len),
    .i_sync      (i_sync),
    .o_en_ce     (o_en_ce),
    .o_en_s      (o_en_s),
    .o_en_bm     (o_en_bm),
    .o_en_acs    (o_en_acs),
    .o_en_m      (o_en_m),
    .o_en_t      (o_en_t),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_sync_err  (o_sync_err),
    .o_state     (o_state)
  );

  always #5 clk = ~clk;

  // Word layout: {state, ce, s, bm, acs, m, t, busy, done, sync_err}.
  function automatic logic [W-1:0] exp_word(input state_t s);
    logic [5:0] e;
    logic       b;
    case (s)
      S_P1:    e = 6'b110000;
      S_P2:    e = 6'b111000;
      S_P3:    e = 6'b111100;
      S_RUN:   e = 6'b111110;
      S_FILL:  e = 6'b110010;
      S_TRACE: e = 6'b110011;
      S_FLUSH: e = 6'b000011;
      default: e = 6'b000000;
    endcase
    b = !(s == S_IDLE || s == S_DONE || s == S_ERR);
    return {4'(s), e, b, s == S_DONE, s == S_ERR};
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check(input string t, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (state got %0d exp %0d)",
               t, got, exp, got[12:9], exp[12:9]);
    end
  endtask

  // Mode/length carry the scenario values only on a start that should be
  // accepted; elsewhere they are scrambled to expose unwanted latching.
  task automatic apply(input logic st, input logic sy, input logic r, input logic e,
                       input state_t ex);
    logic [W-1:0] got;
    i_start = st;
    i_sync  = sy;
    rst     = r;
    en      = e;
    if (st && (cur_st == S_IDLE || cur_st == S_ERR)) begin
      i_mode      = mode_v;
      i_frame_len = len_v;
    end else begin
      i_mode      = rnd();
      i_frame_len = 11'($urandom_range(0, 2047));
    end
    exp_q.push_back(exp_word(ex));
    @(posedge clk);
    #1;
    got = {4'(o_state), o_en_ce, o_en_s, o_en_bm, o_en_acs, o_en_m, o_en_t,
           o_busy, o_done, o_sync_err};
    check(tag, got, exp_q.pop_front());
    cur_st = ex;
  endtask

  task automatic cyc(input logic st, input logic sy, input logic r, input state_t ex);
    if (alt_en && !r) apply(st, sy, r, 1'b0, cur_st);
    apply(st, sy, r, 1'b1, ex);
  endtask

  task automatic start_to_trace(input logic m, input logic [10:0] l, input int nrun);
    mode_v = m;
    len_v  = l;
    cyc(1'b1, 1'b0, 1'b0, S_P1);
    cyc(rnd(), 1'b0, 1'b0, S_P2);
    cyc(rnd(), 1'b0, 1'b0, S_P3);
    cyc(rnd(), 1'b0, 1'b0, S_RUN);
    for (int i = 1; i < nrun; i++) cyc(rnd(), 1'b0, 1'b0, S_RUN);
    cyc(rnd(), 1'b1, 1'b0, S_FILL);
    for (int i = 1; i < 8; i++) cyc(rnd(), rnd(), 1'b0, S_FILL);
    cyc(rnd(), rnd(), 1'b0, S_TRACE);
  endtask

  task automatic trace_frame(input int n);
    for (int i = 1; i < n; i++) cyc(rnd(), rnd(), 1'b0, S_TRACE);
    cyc(rnd(), rnd(), 1'b0, S_FLUSH);
    for (int i = 1; i < 8; i++) cyc(rnd(), rnd(), 1'b0, S_FLUSH);
    cyc(rnd(), rnd(), 1'b0, S_DONE);
    cyc(1'b0, rnd(), 1'b0, S_IDLE);
    cyc(1'b0, rnd(), 1'b0, S_IDLE);
  endtask

  initial begin
    tag = "reset";
    cyc(1'b1, 1'b0, 1'b1, S_IDLE);
    cyc(1'b0, 1'b0, 1'b1, S_IDLE);
    cyc(1'b0, 1'b1, 1'b0, S_IDLE);

    tag = "continuous";
    start_to_trace(1'b0, 11'd5, 3);
    for (int i = 1; i < 1000; i++) cyc(rnd(), rnd(), 1'b0, S_TRACE);
    cyc(1'b0, 1'b0, 1'b1, S_IDLE);

    tag = "framed16";
    start_to_trace(1'b1, 11'd16, 2);
    trace_frame(16);

    tag = "timeout";
    mode_v = 1'b0;
    len_v  = 11'd3;
    cyc(1'b1, 1'b0, 1'b0, S_P1);
    cyc(1'b0, 1'b0, 1'b0, S_P2);
    cyc(1'b0, 1'b0, 1'b0, S_P3);
    cyc(1'b0, 1'b0, 1'b0, S_RUN);
    for (int i = 1; i < 16; i++) cyc(rnd(), 1'b0, 1'b0, S_RUN);
    cyc(1'b0, 1'b0, 1'b0, S_ERR);
    for (int i = 0; i < 3; i++) cyc(1'b0, rnd(), 1'b0, S_ERR);

    tag = "sync_at_timeout_len0";
    start_to_trace(1'b1, 11'd0, 16);
    trace_frame(0);

    tag = "en_alternate";
    alt_en = 1'b1;
    start_to_trace(1'b1, 11'd4, 2);
    trace_frame(4);
    alt_en = 1'b0;

    tag = "rst_in_trace";
    start_to_trace(1'b1, 11'd16, 1);
    for (int i = 0; i < 4; i++) cyc(rnd(), rnd(), 1'b0, S_TRACE);
    cyc(1'b1, 1'b0, 1'b1, S_IDLE);
    cyc(1'b0, 1'b0, 1'b0, S_IDLE);

    tag = "rst_with_en0";
    mode_v = 1'b1;
    len_v  = 11'd2;
    cyc(1'b1, 1'b0, 1'b0, S_P1);
    cyc(1'b0, 1'b0, 1'b0, S_P2);
    cyc(1'b0, 1'b0, 1'b0, S_P3);
    cyc(1'b0, 1'b0, 1'b0, S_RUN);
    apply(1'b0, 1'b1, 1'b1, 1'b0, S_IDLE);
    cyc(1'b0, 1'b1, 1'b0, S_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
